// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
// The group size is fixed at 4 bits.
package cla_pkg;

    localparam int CLA_GROUP = 4;

    function automatic int cla_groups(input int width);
        return width / CLA_GROUP;
    endfunction

endpackage

// File: rtl/cla4_block.sv
// 4-bit lookahead group: sum bits plus group generate/propagate.
// All internal carries are fully expanded from cin, with no chained reuse.
import cla_pkg::*;

module cla4_block (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       gg,
    output logic       gp
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign s  = p ^ c;
    assign gp = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_adder.sv
// Registered carry-lookahead adder: {carry,sum} <= a + b + c0 each clock.
// Groups of 4 bits feed a flattened second-level group-carry network.
import cla_pkg::*;

module cla_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0
);

    localparam int GROUPS = cla_groups(WIDTH);

    if (WIDTH < CLA_GROUP || (WIDTH % CLA_GROUP) != 0) begin : g_bad_width
        $error("cla_adder: WIDTH must be a positive multiple of 4");
    end

    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;
    logic [GROUPS:0]   grp_c;
    logic [WIDTH-1:0]  sum_next;

    assign grp_c[0] = c0;

    for (genvar k = 0; k < GROUPS; k++) begin : g_grp
        cla4_block u_blk (
            .a   (a[4*k +: 4]),
            .b   (b[4*k +: 4]),
            .cin (grp_c[k]),
            .s   (sum_next[4*k +: 4]),
            .gg  (grp_g[k]),
            .gp  (grp_p[k])
        );
    end

    // Carry into group k: OR over j<k of GG[j] propagated through GP[k-1:j+1],
    // plus c0 propagated through every lower group.
    for (genvar k = 1; k <= GROUPS; k++) begin : g_lvl2
        logic [k:0] terms;

        assign terms[k] = c0 & (&grp_p[k-1:0]);

        for (genvar j = 0; j < k; j++) begin : g_term
            if (j == k - 1) begin : g_near
                assign terms[j] = grp_g[j];
            end else begin : g_far
                assign terms[j] = grp_g[j] & (&grp_p[k-1:j+1]);
            end
        end

        assign grp_c[k] = |terms;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            sum   <= sum_next;
            carry <= grp_c[GROUPS];
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// Bench for cla_adder at WIDTH=4 (exhaustive plus directed) and WIDTH=16 (random),
// compared against plain integer addition.
module tb_cla_adder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  a4, b4, s4;
    logic        c4, k4;
    logic [15:0] a16, b16, s16;
    logic        c16, k16;

    int vectors;
    int miscompares;

    cla_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .sum   (s4),
        .carry (k4),
        .a     (a4),
        .b     (b4),
        .c0    (c4)
    );

    cla_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .sum   (s16),
        .carry (k16),
        .a     (a16),
        .b     (b16),
        .c0    (c16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
        int unsigned r;
        r = int'(x) + int'(y) + int'(c);
        return r[4:0];
    endfunction

    function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
        int unsigned r;
        r = int'(x) + int'(y) + int'(c);
        return r[16:0];
    endfunction

    task automatic check4(input string tag, input logic [4:0] expected);
        vectors++;
        assert ({k4, s4} === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, {k4, s4}, expected);
        end
    endtask

    task automatic check16(input string tag, input logic [16:0] expected);
        vectors++;
        assert ({k16, s16} === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, {k16, s16}, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Apply both operand sets, clock once, and return the expected 16-bit result.
    task automatic step(input logic [3:0] ia4, input logic [3:0] ib4, input logic ic4,
                        input logic [15:0] ia16, input logic [15:0] ib16, input logic ic16,
                        output logic [16:0] exp16);
        a4  = ia4;  b4  = ib4;  c4  = ic4;
        a16 = ia16; b16 = ib16; c16 = ic16;
        exp16 = model16(ia16, ib16, ic16);
        cycle();
    endtask

    logic [16:0] e16;
    logic [15:0] ra, rb;
    logic [8:0]  idx;

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        a4 = 4'hf; b4 = 4'hf; c4 = 1'b1;
        a16 = 16'hffff; b16 = 16'hffff; c16 = 1'b1;

        #3;
        check4("reset4", 5'b0_0000);
        check16("reset16", 17'h0);
        #4 rst_n = 1'b1;

        step(4'b1001, 4'b1101, 1'b0, 16'h1234, 16'h4321, 1'b0, e16);
        check4("9+13", 5'b1_0110);
        check16("r16_a", e16);

        step(4'b1100, 4'b1010, 1'b1, 16'hffff, 16'h0000, 1'b1, e16);
        check4("12+10+1", 5'b1_0111);
        check16("ffff+0+1", 17'h1_0000);

        step(4'b1001, 4'b0011, 1'b1, 16'haaaa, 16'h5555, 1'b1, e16);
        check4("9+3+1", 5'b0_1101);
        check16("prop16_c1", 17'h1_0000);

        // Inputs changing between edges must not reach the outputs.
        a4 = 4'hf; b4 = 4'hf; c4 = 1'b1;
        a16 = 16'hffff; b16 = 16'hffff; c16 = 1'b1;
        #3;
        check4("hold4", 5'b0_1101);
        check16("hold16", 17'h1_0000);

        step(4'b1010, 4'b0101, 1'b1, 16'haaaa, 16'h5555, 1'b0, e16);
        check4("prop4_c1", 5'b1_0000);
        check16("prop16_c0", 17'h0_ffff);

        step(4'b1010, 4'b0101, 1'b0, 16'hffff, 16'hffff, 1'b1, e16);
        check4("prop4_c0", 5'b0_1111);
        check16("max16", 17'h1_ffff);

        step(4'b0000, 4'b0000, 1'b0, 16'h0000, 16'h0000, 1'b0, e16);
        check4("zero4", 5'b0_0000);
        check16("zero16", 17'h0);

        step(4'b1111, 4'b1111, 1'b1, 16'h8000, 16'h8000, 1'b0, e16);
        check4("max4", 5'b1_1111);
        check16("msb16", e16);

        // Mid-stream reset: clears without an edge and discards the in-flight result.
        step(4'b1001, 4'b1101, 1'b0, 16'h0f0f, 16'hf0f1, 1'b0, e16);
        check4("pre_rst4", 5'b1_0110);
        check16("pre_rst16", e16);
        a4 = 4'b1111; b4 = 4'b1111; c4 = 1'b1;
        rst_n = 1'b0;
        #2;
        check4("async_rst4", 5'b0_0000);
        check16("async_rst16", 17'h0);
        cycle();
        check4("held_rst4", 5'b0_0000);
        #2 rst_n = 1'b1;
        cycle();
        check4("post_rst4", 5'b1_1111);
        check16("post_rst16", model16(a16, b16, c16));

        // Exhaustive 4-bit, back-to-back, with random 16-bit traffic alongside.
        for (int i = 0; i < 512; i++) begin
            idx = 9'(i);
            ra = 16'($urandom());
            rb = 16'($urandom());
            step(idx[3:0], idx[7:4], idx[8], ra, rb, 1'($urandom()), e16);
            check4("exh4", model4(idx[3:0], idx[7:4], idx[8]));
            check16("rand16", e16);
        end

        for (int i = 0; i < 9500; i++) begin
            ra = 16'($urandom());
            rb = 16'($urandom());
            step(4'($urandom()), 4'($urandom()), 1'($urandom()), ra, rb, 1'($urandom()), e16);
            check4("rand4", model4(a4, b4, c4));
            check16("rand16", e16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
